wb_queue: RTL

- Writeback buffer that drives the register file's write port (DstReg/WriteReg/DstData).
- Accepts results from two producers, the ALU and memory, through valid/ready handshakes.
- Holds results in a small in-order FIFO and retires one result per cycle into the register file.
- Provides youngest-match forwarding of pending writes to the two source-read ports, so reads never see stale data while a write is queued.

---
 rtl/wb_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// Writeback queue: accepts ALU/memory results, retires one per cycle into the
// register file, and forwards the youngest pending write to two read ports.
module wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_W-1:0]  alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_W-1:0]  mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic [REG_W-1:0]  rf_dst_reg,
  output logic              rf_write_reg,
  output logic [DATA_W-1:0] rf_dst_data,
  input  logic [REG_W-1:0]  src1_reg,
  output logic              src1_hit,
  output logic [DATA_W-1:0] src1_data,
  input  logic [REG_W-1:0]  src2_reg,
  output logic              src2_hit,
  output logic [DATA_W-1:0] src2_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FREE_W = CNT_W + 1;

  typedef struct packed {
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_pop;
  logic [FREE_W-1:0] w_free;
  logic              w_mem_ready;
  logic              w_alu_ready;
  logic              w_mem_push;
  logic              w_alu_push;
  logic [PTR_W-1:0]  w_alu_slot;
  logic [PTR_W-1:0]  w_tail_next;
  logic [CNT_W-1:0]  w_count_next;
  entry_t            w_head;

  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty;

  // Free slots include the one vacated by this cycle's pop; memory owns the last slot.
  assign w_free      = FREE_W'(DEPTH) - FREE_W'(r_count) + FREE_W'(w_pop);
  assign w_mem_ready = rst && (w_free >= FREE_W'(1));
  assign w_alu_ready = rst && ((w_free >= FREE_W'(2)) ||
                               ((w_free >= FREE_W'(1)) && !mem_valid));

  // Writes to register 0 complete the handshake but are dropped.
  assign w_mem_push = mem_valid && w_mem_ready && (mem_reg != '0);
  assign w_alu_push = alu_valid && w_alu_ready && (alu_reg != '0);

  assign w_alu_slot   = w_mem_push ? (r_tail + PTR_W'(1)) : r_tail;
  assign w_tail_next  = r_tail + PTR_W'(w_mem_push) + PTR_W'(w_alu_push);
  assign w_count_next = r_count + CNT_W'(w_mem_push) + CNT_W'(w_alu_push) - CNT_W'(w_pop);
  assign w_head       = r_mem[r_head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

  // Storage needs no reset: occupancy gates every use of an entry.
  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_mem[r_tail] <= '{rg: mem_reg, data: mem_data};
    end
    if (w_alu_push) begin
      r_mem[w_alu_slot] <= '{rg: alu_reg, data: alu_data};
    end
  end

  assign alu_ready    = w_alu_ready;
  assign mem_ready    = w_mem_ready;
  assign rf_write_reg = w_pop;
  assign rf_dst_reg   = w_empty ? '0 : w_head.rg;
  assign rf_dst_data  = w_empty ? '0 : w_head.data;
  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = (r_count == CNT_W'(DEPTH));

  // Walk oldest to youngest so the last match wins; head is included while it retires.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    src1_hit  = 1'b0;
    src1_data = '0;
    src2_hit  = 1'b0;
    src2_data = '0;
    w_idx     = r_head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (CNT_W'(i) < r_count) begin
        if ((src1_reg != '0) && (r_mem[w_idx].rg == src1_reg)) begin
          src1_hit  = 1'b1;
          src1_data = r_mem[w_idx].data;
        end
        if ((src2_reg != '0) && (r_mem[w_idx].rg == src2_reg)) begin
          src2_hit  = 1'b1;
          src2_data = r_mem[w_idx].data;
        end
      end
    end
  end

endmodule
